// File: rtl/tx_axis_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI4-Stream sources
// onto the single 64-bit TX stream of the 10G network module.
module tx_axis_packet_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk156,
  input  logic                      aresetn,
  input  logic [NUM_PORTS-1:0]      s_axis_tvalid,
  output logic [NUM_PORTS-1:0]      s_axis_tready,
  input  logic [64*NUM_PORTS-1:0]   s_axis_tdata,
  input  logic [8*NUM_PORTS-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [63:0]               m_axis_tdata,
  output logic [7:0]                m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      grant_valid,
  output logic [2:0]                grant_idx,
  output logic [CNT_WIDTH-1:0]      pkt_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_r;
  state_t                state_s;
  logic [2:0]            grant_idx_r;
  logic [2:0]            last_grant_r;
  logic                  grant_valid_r;
  logic [CNT_WIDTH-1:0]  pkt_count_r;

  logic [2:0]            pick_s;
  logic [2:0]            pick_hi_s;
  logic [2:0]            pick_lo_s;
  logic                  found_hi_s;
  logic                  any_req_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [63:0]           sel_data_s;
  logic [7:0]            sel_keep_s;
  logic                  busy_s;
  logic                  beat_s;
  logic                  done_s;

  // Round-robin pick: lowest requester above last_grant, else lowest requester overall
  always_comb begin
    pick_hi_s  = 3'd0;
    pick_lo_s  = 3'd0;
    found_hi_s = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      pick_lo_s  = s_axis_tvalid[i] ? 3'(i) : pick_lo_s;
      pick_hi_s  = (s_axis_tvalid[i] && (3'(i) > last_grant_r)) ? 3'(i) : pick_hi_s;
      found_hi_s = found_hi_s | (s_axis_tvalid[i] & (3'(i) > last_grant_r));
    end
    pick_s    = found_hi_s ? pick_hi_s : pick_lo_s;
    any_req_s = |s_axis_tvalid;
  end

  // AND-OR multiplexer selecting the granted port's stream
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 64'd0;
    sel_keep_s  = 8'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_valid_s = sel_valid_s | (s_axis_tvalid[i] & (grant_idx_r == 3'(i)));
      sel_last_s  = sel_last_s  | (s_axis_tlast[i]  & (grant_idx_r == 3'(i)));
      sel_data_s  = sel_data_s  | (s_axis_tdata[64*i +: 64] & {64{grant_idx_r == 3'(i)}});
      sel_keep_s  = sel_keep_s  | (s_axis_tkeep[8*i +: 8]   & {8{grant_idx_r == 3'(i)}});
    end
  end

  // State register
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    case (state_r)
      IDLE:    state_s = any_req_s ? BUSY : IDLE;
      BUSY:    state_s = done_s ? IDLE : BUSY;
      default: state_s = IDLE;
    endcase
  end

  // Output logic: link outputs are forced to zero outside BUSY
  always_comb begin
    busy_s        = (state_r == BUSY);
    m_axis_tvalid = busy_s & sel_valid_s;
    m_axis_tlast  = busy_s & sel_last_s;
    m_axis_tdata  = busy_s ? sel_data_s : 64'd0;
    m_axis_tkeep  = busy_s ? sel_keep_s : 8'd0;
    s_axis_tready = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_axis_tready[i] = busy_s & m_axis_tready & (grant_idx_r == 3'(i));
    end
    beat_s = m_axis_tvalid & m_axis_tready;
    done_s = beat_s & m_axis_tlast;
  end

  // Grant bookkeeping and completed-packet counter
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      grant_idx_r   <= 3'd0;
      last_grant_r  <= 3'(NUM_PORTS - 1);
      grant_valid_r <= 1'b0;
      pkt_count_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      if ((state_r == IDLE) && any_req_s) begin
        grant_idx_r   <= pick_s;
        last_grant_r  <= pick_s;
        grant_valid_r <= 1'b1;
      end else if (done_s) begin
        grant_valid_r <= 1'b0;
      end else begin
        grant_valid_r <= grant_valid_r;
      end
      if (done_s) begin
        pkt_count_r <= pkt_count_r + CNT_WIDTH'(1);
      end else begin
        pkt_count_r <= pkt_count_r;
      end
    end
  end

  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign pkt_count   = pkt_count_r;

endmodule
